// File: rtl/instruction_fetch_unit_if.sv
// Purpose: groups the handshake and memory signals of the instruction fetch unit.
// Ports: master = fetch unit (drives MemAddr/MemRead/Instr/Valid/Busy/PC);
//        slave  = environment (drives Start/Flush/PCLoad/PCIn/MemData/Ack).
interface instruction_fetch_unit_if;
  logic        Start;
  logic        Flush;
  logic        PCLoad;
  logic [15:0] PCIn;
  logic [7:0]  MemData;
  logic        Ack;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic [15:0] Instr;
  logic        Valid;
  logic        Busy;
  logic [15:0] PC;

  modport master (
    input  Start, Flush, PCLoad, PCIn, MemData, Ack,
    output MemAddr, MemRead, Instr, Valid, Busy, PC
  );

  modport slave (
    output Start, Flush, PCLoad, PCIn, MemData, Ack,
    input  MemAddr, MemRead, Instr, Valid, Busy, PC
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Purpose: owns the PC and fetches one 16-bit instruction as two little-endian bytes.
// Latency: Valid rises 3 edges after Start is sampled; 4 cycles per back-to-back fetch.
// Backpressure: Instr is held in DONE until Ack; Flush aborts and drops it.
// Ports: Clock, Reset (async, active-high); bus = instruction_fetch_unit_if.master.
module instruction_fetch_unit (
  input logic                      Clock,
  input logic                      Reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_LO = 3'd1,
    CAP_LO = 3'd2,
    CAP_HI = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic [7:0]  lo_byte;
  logic [15:0] instr;
  logic        pc_load_ok;
  logic        pc_inc;

  // A redirect is only safe while no fetch is in flight, unless the same
  // cycle also aborts the fetch.
  assign pc_load_ok = bus.PCLoad &&
                      (bus.Flush || state == IDLE || state == DONE);
  // Both request cycles advance the PC; an abort freezes it where it is.
  assign pc_inc     = !bus.Flush && (state == REQ_LO || state == CAP_LO);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.Flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.Start) state_nxt = REQ_LO;
        REQ_LO:  state_nxt = CAP_LO;
        CAP_LO:  state_nxt = CAP_HI;
        CAP_HI:  state_nxt = DONE;
        DONE: begin
          if (bus.Ack) state_nxt = bus.Start ? REQ_LO : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc <= 16'h0000;
    end else if (pc_load_ok) begin
      pc <= bus.PCIn;
    end else if (pc_inc) begin
      pc <= pc + 16'd1;   // wraps modulo 2^16
    end
  end

  // MemData during CAP_LO answers the REQ_LO request (low byte); during
  // CAP_HI it answers the CAP_LO request (high byte).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lo_byte <= 8'h00;
      instr   <= 16'h0000;
    end else if (!bus.Flush) begin
      if (state == CAP_LO) lo_byte <= bus.MemData;
      if (state == CAP_HI) instr   <= {bus.MemData, lo_byte};
    end
  end

  assign bus.MemAddr = pc;
  assign bus.MemRead = (state == REQ_LO) || (state == CAP_LO);
  assign bus.Instr   = instr;
  assign bus.Valid   = (state == DONE);
  assign bus.Busy    = (state == REQ_LO) || (state == CAP_LO) || (state == CAP_HI);
  assign bus.PC      = pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Synchronous byte memory: data for the address requested in cycle n
  // appears during cycle n+1.
  logic [7:0] mem [0:65535];
  always @(posedge Clock) begin
    if (bus.MemRead) bus.MemData <= mem[bus.MemAddr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the consumer should see, tracked per completed fetch.
  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_instr = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Launch one fetch from IDLE or DONE and follow it to completion.
  task automatic fetch(input logic [15:0] a, input bit load, input bit ack_too,
                       input string tag);
    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] exp_instr;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    exp_instr = {mem[a1], mem[a]};
    bus.Start  = 1'b1;
    bus.Ack    = ack_too;
    bus.PCLoad = load;
    bus.PCIn   = a;
    step();
    bus.Start  = 1'b0;
    bus.Ack    = 1'b0;
    bus.PCLoad = 1'b0;
    chk({tag, "/req_addr"},  bus.MemAddr, a);
    chk({tag, "/req_rd"},    bus.MemRead, 1);
    chk({tag, "/req_busy"},  bus.Busy, 1);
    chk({tag, "/req_valid"}, bus.Valid, 0);
    chk({tag, "/req_instr"}, bus.Instr, m_instr);
    step();
    chk({tag, "/cap_addr"},  bus.MemAddr, a1);
    chk({tag, "/cap_rd"},    bus.MemRead, 1);
    step();
    chk({tag, "/hi_rd"},     bus.MemRead, 0);
    chk({tag, "/hi_busy"},   bus.Busy, 1);
    chk({tag, "/hi_valid"},  bus.Valid, 0);
    chk({tag, "/hi_pc"},     bus.PC, a2);
    step();
    chk({tag, "/valid"},     bus.Valid, 1);
    chk({tag, "/busy"},      bus.Busy, 0);
    chk({tag, "/instr"},     bus.Instr, exp_instr);
    chk({tag, "/pc"},        bus.PC, a2);
    m_instr = exp_instr;
    m_pc    = a2;
  endtask

  task automatic release_to_idle(input string tag);
    bus.Ack = 1'b1;
    step();
    bus.Ack = 1'b0;
    chk({tag, "/idle_valid"}, bus.Valid, 0);
    chk({tag, "/idle_busy"},  bus.Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    bit          in_done;
    int          hold;

    bus.Start = 0; bus.Flush = 0; bus.PCLoad = 0; bus.PCIn = 0; bus.Ack = 0;
    bus.MemData = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
    mem[16'h0020] = 8'hCD; mem[16'h0021] = 8'hAB;
    mem[16'h0022] = 8'h01; mem[16'h0023] = 8'hEF;
    mem[16'hFFFF] = 8'h55; mem[16'h0000] = 8'hAA;

    // Reset values
    #2;
    chk("rst/pc", bus.PC, 16'h0000);
    chk("rst/instr", bus.Instr, 16'h0000);
    chk("rst/valid", bus.Valid, 0);
    chk("rst/busy", bus.Busy, 0);
    chk("rst/rd", bus.MemRead, 0);
    chk("rst/addr", bus.MemAddr, 16'h0000);
    @(posedge Clock); #1;
    Reset = 1'b0;
    step();
    chk("idle/valid", bus.Valid, 0);

    // First fetch with redirect to 0x0010
    fetch(16'h0010, 1, 0, "first");
    chk("first/exact", bus.Instr, 16'h1234);

    // Consumer stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall/valid", bus.Valid, 1);
      chk("stall/instr", bus.Instr, 16'h1234);
      chk("stall/rd", bus.MemRead, 0);
      chk("stall/pc", bus.PC, 16'h0012);
    end
    release_to_idle("stall");

    // Back-to-back pair from 0x0020
    fetch(16'h0020, 1, 0, "b2b0");
    chk("b2b0/exact", bus.Instr, 16'hABCD);
    fetch(m_pc, 0, 1, "b2b1");
    chk("b2b1/exact", bus.Instr, 16'hEF01);
    chk("b2b1/pc", bus.PC, 16'h0024);
    release_to_idle("b2b");

    // Address wrap
    fetch(16'hFFFF, 1, 0, "wrap");
    chk("wrap/exact", bus.Instr, 16'hAA55);
    chk("wrap/pc", bus.PC, 16'h0001);
    release_to_idle("wrap");

    // Flush + redirect during CAP_LO
    bus.Start = 1; bus.PCLoad = 1; bus.PCIn = 16'h0200;
    step();
    bus.Start = 0; bus.PCLoad = 0;
    step();
    chk("flush/in_caplo", bus.MemAddr, 16'h0201);
    bus.Flush = 1; bus.PCLoad = 1; bus.PCIn = 16'h0100;
    step();
    bus.Flush = 0; bus.PCLoad = 0;
    chk("flush/valid", bus.Valid, 0);
    chk("flush/busy", bus.Busy, 0);
    chk("flush/pc", bus.PC, 16'h0100);
    chk("flush/instr", bus.Instr, m_instr);
    m_pc = 16'h0100;
    step();
    chk("flush/stays_idle", bus.Valid, 0);

    // PCLoad alone during CAP_LO is ignored
    bus.Start = 1;
    step();
    bus.Start = 0;
    step();
    bus.PCLoad = 1; bus.PCIn = 16'h5555;
    step();
    bus.PCLoad = 0;
    chk("noload/pc", bus.PC, 16'h0102);
    step();
    chk("noload/valid", bus.Valid, 1);
    chk("noload/instr", bus.Instr, {mem[16'h0101], mem[16'h0100]});
    chk("noload/pc2", bus.PC, 16'h0102);
    m_instr = {mem[16'h0101], mem[16'h0100]};
    m_pc = 16'h0102;
    release_to_idle("noload");

    // Randomized fetches, redirects, stalls and back-to-back starts
    in_done = 0;
    for (int it = 0; it < 25; it++) begin
      bit load;
      bit b2b;
      load = ($urandom_range(0, 1) == 1);
      b2b  = in_done && ($urandom_range(0, 1) == 1);
      if (in_done && !b2b) release_to_idle("rnd");
      a = load ? 16'($urandom) : m_pc;
      mem[a]         = 8'($urandom);
      mem[a + 16'd1] = 8'($urandom);
      fetch(a, load, b2b, "rnd");
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        step();
        chk("rnd/hold_valid", bus.Valid, 1);
        chk("rnd/hold_instr", bus.Instr, m_instr);
        chk("rnd/hold_pc", bus.PC, m_pc);
      end
      in_done = 1;
    end
    release_to_idle("rnd_end");

    // Reset asserted during CAP_HI
    bus.Start = 1;
    step();
    bus.Start = 0;
    step();
    step();
    chk("rst2/in_caphi", bus.Busy, 1);
    Reset = 1'b1;
    #1;
    chk("rst2/pc", bus.PC, 16'h0000);
    chk("rst2/instr", bus.Instr, 16'h0000);
    chk("rst2/valid", bus.Valid, 0);
    chk("rst2/busy", bus.Busy, 0);
    chk("rst2/rd", bus.MemRead, 0);
    chk("rst2/addr", bus.MemAddr, 16'h0000);
    step();
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst2/no_valid", bus.Valid, 0);
      chk("rst2/no_busy", bus.Busy, 0);
      chk("rst2/instr_hold", bus.Instr, 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
